// File: rtl/pixel_stream_sched.sv
// pixel_stream_sched: read-side scheduler for the camera pixel FIFO (HDMI clock domain).
// Primes the FIFO before each frame, paces reads with the display data-enable,
// flushes and resynchronises on underflow or frame misalignment, and expands
// RGB565 to RGB888 for the HDMI encoder.
// Optional build macro: PIXEL_STREAM_SCHED_STATS_EN enables the saturating
// underflow/misalignment counters; without it both counter outputs read 0.
module pixel_stream_sched #(
  parameter int FRAME_PIXELS = 921600,
  parameter int PIX_CNT_W    = 20,
  parameter int PRIME_LEVEL  = 8
) (
  input  logic        i_hdmi_clk,
  input  logic        i_rst_n,
  input  logic        i_init_done,
  input  logic        i_frame_start,
  input  logic        i_de,
  input  logic        i_fifo_empty,
  input  logic [4:0]  i_fifo_rd_count,
  input  logic [15:0] i_fifo_dout,
  output logic        o_fifo_rden,
  output logic [23:0] o_rgb8,
  output logic        o_rgb8_valid,
  output logic [2:0]  o_state,
  output logic [7:0]  o_underflow_cnt,
  output logic [7:0]  o_misalign_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PRIME  = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

  localparam logic [PIX_CNT_W-1:0] FRAME_CNT = PIX_CNT_W'(FRAME_PIXELS);
  localparam logic [4:0]           PRIME_THR = 5'(PRIME_LEVEL);

  state_t               state_q, state_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  // Stage 1 of the delay line: data-enable and "a presentable read was issued".
  logic                 tag_valid_q, tag_valid_d;
  logic                 tag_read_q, tag_read_d;
  // Stage 2: registered expanded pixel and its qualifier.
  logic [23:0]          rgb_q, rgb_d;
  logic                 rgb_valid_q, rgb_valid_d;

  logic rden;
  logic underflow_evt;
  logic misalign_evt;

  // FIFO read enable: paced by DE while streaming, free-running while flushing.
  always_comb begin
    rden = 1'b0;
    case (state_q)
      ST_STREAM: rden = i_de & ~i_fifo_empty;
      ST_FLUSH:  rden = ~i_fifo_empty;
      default:   rden = 1'b0;
    endcase
    if (!i_rst_n) rden = 1'b0;
  end

  // Next-state, pixel counter and error events.
  always_comb begin
    underflow_evt = (state_q == ST_STREAM) & i_de & i_fifo_empty;
    misalign_evt  = (state_q == ST_STREAM) & i_frame_start & (pix_cnt_q != FRAME_CNT);
    state_d       = state_q;
    pix_cnt_d     = '0;
    case (state_q)
      ST_IDLE:  if (i_init_done) state_d = ST_SYNC;
      ST_SYNC:  if (i_frame_start) state_d = ST_PRIME;
      // A frame start while priming simply keeps us priming for the new frame.
      ST_PRIME: if (!i_frame_start && (i_fifo_rd_count >= PRIME_THR) && !i_de)
                  state_d = ST_STREAM;
      ST_STREAM: begin
        pix_cnt_d = i_frame_start ? '0 : pix_cnt_q + PIX_CNT_W'(i_de);
        if (underflow_evt || misalign_evt) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (i_fifo_empty) state_d = ST_SYNC;
      default:  state_d = ST_IDLE;
    endcase
    if (!i_init_done) state_d = ST_IDLE;
  end

  // Delay-line inputs and RGB565 -> RGB888 expansion by bit replication.
  always_comb begin
    tag_valid_d = i_de & (state_q != ST_IDLE);
    tag_read_d  = rden & (state_q == ST_STREAM);
    rgb_valid_d = tag_valid_q;
    rgb_d       = '0;
    if (tag_read_q)
      rgb_d = {i_fifo_dout[15:11], i_fifo_dout[15:13],
               i_fifo_dout[10:5],  i_fifo_dout[10:9],
               i_fifo_dout[4:0],   i_fifo_dout[4:2]};
  end

  // State, counter and delay-line registers; reset clears the pipeline too.
  always_ff @(posedge i_hdmi_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      tag_valid_q <= 1'b0;
      tag_read_q  <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_read_q  <= tag_read_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

`ifdef PIXEL_STREAM_SCHED_STATS_EN
  logic [7:0] uf_cnt_q, uf_cnt_d;
  logic [7:0] mis_cnt_q, mis_cnt_d;

  // Saturating error counters: an event at 255 leaves the count unchanged.
  always_comb begin
    uf_cnt_d  = uf_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (underflow_evt && (uf_cnt_q != 8'hFF))  uf_cnt_d  = uf_cnt_q + 8'd1;
    if (misalign_evt  && (mis_cnt_q != 8'hFF)) mis_cnt_d = mis_cnt_q + 8'd1;
  end

  // Error counter registers.
  always_ff @(posedge i_hdmi_clk) begin
    if (!i_rst_n) begin
      uf_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      uf_cnt_q  <= uf_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_underflow_cnt = uf_cnt_q;
  assign o_misalign_cnt  = mis_cnt_q;
`else
  assign o_underflow_cnt = '0;
  assign o_misalign_cnt  = '0;
`endif

  assign o_fifo_rden  = rden;
  assign o_rgb8       = rgb_q;
  assign o_rgb8_valid = rgb_valid_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_pixel_stream_sched.sv
// Testbench for pixel_stream_sched: a queue-based FIFO, a spec-level reference
// model of the scheduler, and one task per scenario.
module tb_pixel_stream_sched;
  localparam int FP = 64;
  localparam int PL = 8;
`ifdef PIXEL_STREAM_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, init_done = 1'b0, frame_start = 1'b0, de = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [4:0]  rd_count = '0;
  logic [15:0] fifo_dout = '0;
  logic        o_fifo_rden, o_rgb8_valid;
  logic [23:0] o_rgb8;
  logic [2:0]  o_state;
  logic [7:0]  o_underflow_cnt, o_misalign_cnt;

  always #5 clk = ~clk;

  pixel_stream_sched #(.FRAME_PIXELS(FP), .PIX_CNT_W(20), .PRIME_LEVEL(PL)) dut (
    .i_hdmi_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done),
    .i_frame_start(frame_start), .i_de(de), .i_fifo_empty(fifo_empty),
    .i_fifo_rd_count(rd_count), .i_fifo_dout(fifo_dout),
    .o_fifo_rden(o_fifo_rden), .o_rgb8(o_rgb8), .o_rgb8_valid(o_rgb8_valid),
    .o_state(o_state), .o_underflow_cnt(o_underflow_cnt), .o_misalign_cnt(o_misalign_cnt));

  int n_tests = 0, n_fail = 0;

  // Reference model state (states: 0 idle, 1 sync, 2 prime, 3 stream, 4 flush).
  int          m_st = 0, m_cnt = 0, m_uf = 0, m_mis = 0;
  bit          m_v1 = 0, m_v2 = 0, cur_v = 0;
  logic [23:0] m_p1 = '0, m_p2 = '0, cur_px = '0;
  logic [15:0] q[$];
  bit          exp_rden = 0, exp_valid = 0;
  int          exp_state = 0;
  logic [23:0] exp_rgb = '0;

  function automatic logic [23:0] expand(input logic [15:0] d);
    int r, g, b;
    r = int'(d) / 2048;
    g = (int'(d) / 32) % 64;
    b = int'(d) % 32;
    return 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Present FIFO status for this cycle, compute expectations, move to the sample point.
  task automatic cycle_begin();
    fifo_empty = (q.size() == 0);
    rd_count   = (q.size() > 31) ? 5'd31 : 5'(q.size());
    exp_rden   = rst_n && ((m_st == 3 && de && !fifo_empty) || (m_st == 4 && !fifo_empty));
    cur_v      = de && (m_st != 0);
    cur_px     = (m_st == 3 && exp_rden) ? expand(q[0]) : 24'h0;
    exp_state  = m_st;
    exp_valid  = m_v2;
    exp_rgb    = m_p2;
    @(negedge clk);
  endtask

  // Clock edge: FIFO pop and reference-model update.
  task automatic cycle_end();
    int nst;
    bit uf, mis;
    @(posedge clk);
    #1;
    if (exp_rden) fifo_dout = q.pop_front();
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_uf = 0; m_mis = 0;
      m_v1 = 0; m_v2 = 0; m_p1 = '0; m_p2 = '0;
    end else begin
      uf  = (m_st == 3) && de && fifo_empty;
      mis = (m_st == 3) && frame_start && (m_cnt != FP);
      if (uf)  m_uf  = sat(m_uf + 1);
      if (mis) m_mis = sat(m_mis + 1);
      m_v2 = m_v1; m_p2 = m_p1; m_v1 = cur_v; m_p1 = cur_px;
      nst = m_st;
      case (m_st)
        0: if (init_done) nst = 1;
        1: if (frame_start) nst = 2;
        2: if (!frame_start && int'(rd_count) >= PL && !de) nst = 3;
        3: if (uf || mis) nst = 4;
        4: if (fifo_empty) nst = 1;
        default: nst = 0;
      endcase
      m_cnt = (m_st == 3) ? (frame_start ? 0 : m_cnt + int'(de)) : 0;
      if (!init_done) nst = 0;
      m_st = nst;
    end
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 0; init_done = 0; frame_start = 0; de = 0;
    repeat (3) begin cycle_begin(); cycle_end(); end
    rst_n = 1;
    cycle_begin();
    n_tests++;
    if (o_state !== 3'd0 || o_fifo_rden !== 1'b0 || o_rgb8 !== 24'h0 || o_rgb8_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: state %0d rden %b rgb %h valid %b, want 0 0 000000 0",
               o_state, o_fifo_rden, o_rgb8, o_rgb8_valid);
    end
    n_tests++;
    if (o_underflow_cnt !== 8'd0 || o_misalign_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counters: uf %0d mis %0d, want 0 0", o_underflow_cnt, o_misalign_cnt);
    end
    cycle_end();
    cycle_begin();
    n_tests++;
    if (o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_hold: state %0d, want 0", o_state);
    end
    cycle_end();
    $display("[TB] test_reset done");
  endtask

  task automatic test_bringup();
    init_done = 1;
    for (int i = 0; i < 16; i++) begin
      frame_start = (i == 3);
      if (i >= 5 && q.size() < 10) q.push_back((q.size() == 0) ? 16'hF81F :
                                                (q.size() == 1) ? 16'h07E0 : 16'($urandom));
      cycle_begin();
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL bringup cyc %0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 i, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      cycle_end();
    end
    frame_start = 0;
    cycle_begin();
    n_tests++;
    if (o_state !== 3'd3) begin
      n_fail++;
      $display("FAIL bringup_stream: state %0d, want 3", o_state);
    end
    cycle_end();
    $display("[TB] test_bringup done");
  endtask

  task automatic test_pixel_path();
    for (int i = 0; i < 4; i++) begin
      de = (i < 2);
      if (q.size() < 20) push_rand(1);
      cycle_begin();
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL pixel_path cyc %0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 i, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      if (i == 2) begin
        n_tests++;
        if (o_rgb8 !== 24'hFF00FF || o_rgb8_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL magenta: rgb %h valid %b, want ff00ff 1", o_rgb8, o_rgb8_valid);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (o_rgb8 !== 24'h00FF00 || o_rgb8_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL green: rgb %h valid %b, want 00ff00 1", o_rgb8, o_rgb8_valid);
        end
      end
      cycle_end();
    end
    $display("[TB] test_pixel_path done");
  endtask

  task automatic test_aligned_frames();
    int target, sent, guard;
    for (int f = 0; f < 2; f++) begin
      target = FP - m_cnt; sent = 0; guard = 0;
      while (guard < 400) begin
        guard++;
        de = (sent < target) && ($urandom_range(0, 3) != 0);
        frame_start = (sent >= target);
        if (de) sent++;
        if (q.size() < 20) push_rand(1);
        cycle_begin();
        n_tests++;
        if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
          n_fail++;
          $display("FAIL aligned f%0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                   f, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
        end
        cycle_end();
        if (frame_start) break;
      end
      frame_start = 0; de = 0;
      cycle_begin();
      n_tests++;
      if (o_state !== 3'd3 || o_misalign_cnt !== 8'd0 || guard >= 400) begin
        n_fail++;
        $display("FAIL aligned_frame%0d: state %0d mis %0d, want 3 0", f, o_state, o_misalign_cnt);
      end
      cycle_end();
    end
    $display("[TB] test_aligned_frames done");
  endtask

  task automatic test_underflow();
    bit found;
    found = 0; de = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle_begin();
      found = fifo_empty;
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL underflow_run: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      cycle_end();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL underflow_timeout: fifo never ran empty, want empty within 40 cycles");
    end
    de = 0; push_rand(3);
    cycle_begin();
    n_tests++;
    if (o_state !== 3'd4 || o_underflow_cnt !== (STATS ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL underflow_flush: state %0d uf %0d, want 4 %0d", o_state, o_underflow_cnt, STATS ? 1 : 0);
    end
    cycle_end();
    cycle_begin();
    n_tests++;
    if (o_rgb8 !== 24'h0 || o_rgb8_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_black: rgb %h valid %b, want 000000 1", o_rgb8, o_rgb8_valid);
    end
    cycle_end();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle_begin();
      found = (o_state === 3'd1);
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL underflow_drain: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      cycle_end();
    end
    n_tests++;
    if (!found || q.size() != 0) begin
      n_fail++;
      $display("FAIL underflow_resync: state %0d fifo words %0d, want 1 0", o_state, q.size());
    end
    $display("[TB] test_underflow done");
  endtask

  task automatic test_misalign();
    bit found;
    // Schedule: frame start, prime, 60 pixels, blank, early frame start.
    for (int i = 0; i < 64; i++) begin
      frame_start = (i == 0) || (i == 63);
      de = (i >= 2 && i < 62);
      if (i == 1) push_rand(10);
      if (i >= 2 && q.size() < 20) push_rand(1);
      cycle_begin();
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL misalign cyc %0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 i, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      cycle_end();
    end
    frame_start = 0; de = 0;
    cycle_begin();
    n_tests++;
    if (o_state !== 3'd4 || o_misalign_cnt !== (STATS ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL misalign_flush: state %0d mis %0d, want 4 %0d", o_state, o_misalign_cnt, STATS ? 1 : 0);
    end
    cycle_end();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle_begin();
      found = (o_state === 3'd1);
      cycle_end();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL misalign_resync: state %0d, want 1 within 40 cycles", o_state);
    end
    $display("[TB] test_misalign done");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 12; i++) begin
        frame_start = (i == 0);
        de = (i >= 2 && i <= 10);
        if (i == 1) push_rand(PL);
        cycle_begin();
        n_tests++;
        if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
          n_fail++;
          $display("FAIL saturation it %0d cyc %0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                   k, i, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
        end
        cycle_end();
      end
    end
    frame_start = 0; de = 0;
    cycle_begin();
    n_tests++;
    if (o_underflow_cnt !== (STATS ? 8'd255 : 8'd0) || o_state !== 3'd1) begin
      n_fail++;
      $display("FAIL saturation_hold: uf %0d state %0d, want %0d 1", o_underflow_cnt, o_state, STATS ? 255 : 0);
    end
    cycle_end();
    $display("[TB] test_saturation done");
  endtask

  task automatic test_abort();
    for (int i = 0; i < 10; i++) begin
      frame_start = (i == 0);
      de = (i >= 3);
      if (i == 1) push_rand(10);
      if (q.size() < 20) push_rand(1);
      init_done = (i < 6);
      cycle_begin();
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL abort cyc %0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 i, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      if (i == 7) begin
        n_tests++;
        if (o_state !== 3'd0 || o_fifo_rden !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_idle: state %0d rden %b, want 0 0", o_state, o_fifo_rden);
        end
      end
      if (i == 9) begin
        n_tests++;
        if (o_rgb8_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_valid: valid %b, want 0", o_rgb8_valid);
        end
      end
      cycle_end();
    end
    de = 0; frame_start = 0; init_done = 1;
    $display("[TB] test_abort done");
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 12; i++) begin
      frame_start = (i == 1);
      de = (i >= 4);
      if (i == 2) push_rand(10);
      if (q.size() < 20) push_rand(1);
      rst_n = (i != 8);
      cycle_begin();
      n_tests++;
      if (o_state !== 3'(exp_state) || o_fifo_rden !== exp_rden || o_rgb8_valid !== exp_valid || o_rgb8 !== exp_rgb) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: state %0d/%0d rden %b/%b valid %b/%b rgb %h/%h (got/want)",
                 i, o_state, exp_state, o_fifo_rden, exp_rden, o_rgb8_valid, exp_valid, o_rgb8, exp_rgb);
      end
      if (i == 9) begin
        n_tests++;
        if (o_state !== 3'd0 || o_rgb8_valid !== 1'b0 || o_rgb8 !== 24'h0 ||
            o_underflow_cnt !== 8'd0 || o_misalign_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL reset_mid_clear: state %0d valid %b rgb %h uf %0d mis %0d, want all 0",
                   o_state, o_rgb8_valid, o_rgb8, o_underflow_cnt, o_misalign_cnt);
        end
      end
      cycle_end();
    end
    de = 0; frame_start = 0; rst_n = 1;
    $display("[TB] test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_pixel_path();
    test_aligned_frames();
    test_underflow();
    test_misalign();
    test_saturation();
    test_abort();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
